index_pulse_decoder: RTL and testbench

Sequential counterpart of the priority encoder: accepts a binary index (the encoder's `out`/`valid` pair) over a valid/ready handshake and drives the matching one-hot line for a programmable number of cycles. It sits between arbitration/selection logic and per-line consumers, such as enables, grants or strobes, that need a held one-hot pulse. Indices that are out of range are rejected with an error pulse.

---
 rtl/index_pulse_decoder_pkg.sv | 4 +
 rtl/onehot_decoder.sv | 15 +
 rtl/index_pulse_decoder.sv | 63 ++++++
 tb/tb_index_pulse_decoder.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/index_pulse_decoder_pkg.sv
// index_pulse_decoder_pkg: FSM state type shared by the index pulse decoder
package index_pulse_decoder_pkg;
  typedef enum logic {IDLE, ACTIVE} state_e;
endpackage

// File: rtl/onehot_decoder.sv
// onehot_decoder: index/en -> onehot (1<<index when en and in range), in_range (index < OUTPUT_LINES)
module onehot_decoder #(
  parameter int OUTPUT_LINES = 4,
  parameter int INDEX_WIDTH  = $clog2(OUTPUT_LINES)
) (
  input  logic [INDEX_WIDTH-1:0]  index,
  input  logic                    en,
  output logic [OUTPUT_LINES-1:0] onehot,
  output logic                    in_range
);
  assign in_range = int'(index) < OUTPUT_LINES;
  for (genvar i = 0; i < OUTPUT_LINES; i++) begin : g_line
    assign onehot[i] = en && in_range && int'(index) == i;
  end
endmodule

// File: rtl/index_pulse_decoder.sv
// index_pulse_decoder: accepts in_index over in_valid/in_ready, holds onehot_out/active for HOLD_CYCLES, pulses err on out-of-range
module index_pulse_decoder
  import index_pulse_decoder_pkg::*;
#(
  parameter int OUTPUT_LINES = 4,
  parameter int INDEX_WIDTH  = $clog2(OUTPUT_LINES),
  parameter int HOLD_CYCLES  = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  input  logic [INDEX_WIDTH-1:0]  in_index,
  output logic                    in_ready,
  output logic [OUTPUT_LINES-1:0] onehot_out,
  output logic                    active,
  output logic                    err
);
  localparam int CW = $clog2(HOLD_CYCLES + 1) > 1 ? $clog2(HOLD_CYCLES + 1) : 1;
  if (OUTPUT_LINES < 2 || HOLD_CYCLES < 1) begin : g_bad_params
    $error("index_pulse_decoder: OUTPUT_LINES must be >= 2 and HOLD_CYCLES >= 1");
  end
  state_e                  state_q;
  logic [CW-1:0]           cnt_q;
  logic [OUTPUT_LINES-1:0] onehot_q;
  logic                    err_q;
  logic [OUTPUT_LINES-1:0] onehot_d;
  logic                    in_range;
  logic                    last;
  logic                    accept;
  onehot_decoder #(.OUTPUT_LINES(OUTPUT_LINES), .INDEX_WIDTH(INDEX_WIDTH)) u_dec (
    .index    (in_index),
    .en       (in_valid),
    .onehot   (onehot_d),
    .in_range (in_range)
  );
  assign last       = cnt_q == CW'(HOLD_CYCLES - 1);
  assign in_ready   = !rst && (state_q == IDLE || last);
  assign accept     = in_valid && in_ready;
  assign onehot_out = onehot_q;
  assign active     = state_q == ACTIVE;
  assign err        = err_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      onehot_q <= '0;
      err_q    <= 1'b0;
    end else begin
      err_q <= accept && !in_range;
      if (accept && in_range) begin
        state_q  <= ACTIVE;
        cnt_q    <= '0;
        onehot_q <= onehot_d;
      end else if (state_q == ACTIVE && !last) begin
        cnt_q <= cnt_q + 1'b1;
      end else begin
        state_q  <= IDLE;
        cnt_q    <= '0;
        onehot_q <= '0;
      end
    end
  end
endmodule

// File: tb/tb_index_pulse_decoder.sv
// tb_index_pulse_decoder: directed self-checking bench over five parameterisations
module tb_index_pulse_decoder;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  int n_chk = 0;
  int n_fail = 0;
  logic a_rst, a_v, a_rdy, a_act, a_err;
  logic [1:0] a_idx;
  logic [3:0] a_oh;
  logic b_rst, b_v, b_rdy, b_act, b_err;
  logic [1:0] b_idx;
  logic [3:0] b_oh;
  logic c_rst, c_v, c_rdy, c_act, c_err;
  logic [1:0] c_idx;
  logic [3:0] c_oh;
  logic d_rst, d_v, d_rdy, d_act, d_err;
  logic [2:0] d_idx;
  logic [4:0] d_oh;
  logic e_rst, e_v, e_rdy, e_act, e_err;
  logic [1:0] e_idx;
  logic [3:0] e_oh;
  index_pulse_decoder #(.OUTPUT_LINES(4), .HOLD_CYCLES(1)) dut_a (
    .clk(clk), .rst(a_rst), .in_valid(a_v), .in_index(a_idx), .in_ready(a_rdy),
    .onehot_out(a_oh), .active(a_act), .err(a_err));
  index_pulse_decoder #(.OUTPUT_LINES(4), .HOLD_CYCLES(3)) dut_b (
    .clk(clk), .rst(b_rst), .in_valid(b_v), .in_index(b_idx), .in_ready(b_rdy),
    .onehot_out(b_oh), .active(b_act), .err(b_err));
  index_pulse_decoder #(.OUTPUT_LINES(4), .HOLD_CYCLES(2)) dut_c (
    .clk(clk), .rst(c_rst), .in_valid(c_v), .in_index(c_idx), .in_ready(c_rdy),
    .onehot_out(c_oh), .active(c_act), .err(c_err));
  index_pulse_decoder #(.OUTPUT_LINES(5), .HOLD_CYCLES(2)) dut_d (
    .clk(clk), .rst(d_rst), .in_valid(d_v), .in_index(d_idx), .in_ready(d_rdy),
    .onehot_out(d_oh), .active(d_act), .err(d_err));
  index_pulse_decoder #(.OUTPUT_LINES(4), .HOLD_CYCLES(4)) dut_e (
    .clk(clk), .rst(e_rst), .in_valid(e_v), .in_index(e_idx), .in_ready(e_rdy),
    .onehot_out(e_oh), .active(e_act), .err(e_err));
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  initial begin
    {a_rst, b_rst, c_rst, d_rst, e_rst} = '1;
    {a_v, b_v, c_v, d_v, e_v} = '0;
    a_idx = 2'd2; b_idx = '0; c_idx = '0; d_idx = '0; e_idx = '0;
    a_v = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("a_rst_rdy", a_rdy, 0);
      chk("a_rst_oh", a_oh, 0);
      chk("a_rst_act", a_act, 0);
      chk("a_rst_err", a_err, 0);
    end
    {a_rst, b_rst, c_rst, d_rst, e_rst} = '0;
    #1;
    chk("a_rel_rdy", a_rdy, 1);
    chk("a_rel_oh", a_oh, 0);
    chk("b_rel_rdy", b_rdy, 1);
    cyc();
    chk("a_pulse_oh", a_oh, 4'b0100);
    chk("a_pulse_act", a_act, 1);
    chk("a_pulse_rdy", a_rdy, 1);
    a_v = 1'b0;
    cyc();
    chk("a_end_oh", a_oh, 0);
    chk("a_end_act", a_act, 0);
    b_v = 1'b1; b_idx = 2'd1;
    cyc();
    b_v = 1'b0;
    chk("b_n1_oh", b_oh, 4'b0010);
    chk("b_n1_act", b_act, 1);
    chk("b_n1_rdy", b_rdy, 0);
    cyc();
    chk("b_n2_oh", b_oh, 4'b0010);
    chk("b_n2_rdy", b_rdy, 0);
    cyc();
    chk("b_n3_oh", b_oh, 4'b0010);
    chk("b_n3_act", b_act, 1);
    chk("b_n3_rdy", b_rdy, 1);
    cyc();
    chk("b_n4_oh", b_oh, 0);
    chk("b_n4_act", b_act, 0);
    c_v = 1'b1; c_idx = 2'd0;
    cyc();
    chk("c_1_oh", c_oh, 4'b0001);
    chk("c_1_rdy", c_rdy, 0);
    cyc();
    chk("c_2_oh", c_oh, 4'b0001);
    chk("c_2_rdy", c_rdy, 1);
    c_idx = 2'd3;
    cyc();
    chk("c_3_oh", c_oh, 4'b1000);
    chk("c_3_act", c_act, 1);
    cyc();
    chk("c_4_oh", c_oh, 4'b1000);
    c_idx = 2'd2;
    cyc();
    chk("c_5_oh", c_oh, 4'b0100);
    chk("c_5_act", c_act, 1);
    c_v = 1'b0;
    cyc();
    chk("c_6_oh", c_oh, 4'b0100);
    chk("c_6_act", c_act, 1);
    cyc();
    chk("c_7_oh", c_oh, 0);
    chk("c_7_act", c_act, 0);
    d_v = 1'b1; d_idx = 3'd6;
    chk("d_idle_rdy", d_rdy, 1);
    cyc();
    d_v = 1'b0;
    chk("d_oor_err", d_err, 1);
    chk("d_oor_oh", d_oh, 0);
    chk("d_oor_act", d_act, 0);
    chk("d_oor_rdy", d_rdy, 1);
    cyc();
    chk("d_oor_err_clr", d_err, 0);
    d_v = 1'b1; d_idx = 3'd4;
    cyc();
    chk("d_l4_oh", d_oh, 5'b10000);
    chk("d_l4_rdy", d_rdy, 0);
    d_idx = 3'd6;
    cyc();
    chk("d_l4_last_oh", d_oh, 5'b10000);
    chk("d_l4_last_rdy", d_rdy, 1);
    chk("d_l4_last_err", d_err, 0);
    cyc();
    d_v = 1'b0;
    chk("d_oor2_err", d_err, 1);
    chk("d_oor2_act", d_act, 0);
    chk("d_oor2_oh", d_oh, 0);
    cyc();
    chk("d_oor2_err_clr", d_err, 0);
    chk("d_oor2_idle_act", d_act, 0);
    e_v = 1'b1; e_idx = 2'd3;
    cyc();
    e_v = 1'b0;
    chk("e_1_oh", e_oh, 4'b1000);
    cyc();
    chk("e_2_oh", e_oh, 4'b1000);
    e_rst = 1'b1;
    #1;
    chk("e_rst_rdy", e_rdy, 0);
    cyc();
    chk("e_rst_oh", e_oh, 0);
    chk("e_rst_act", e_act, 0);
    e_rst = 1'b0; e_v = 1'b1; e_idx = 2'd0;
    cyc();
    e_v = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("e_re_oh", e_oh, 4'b0001);
      chk("e_re_act", e_act, 1);
      cyc();
    end
    chk("e_re_end_oh", e_oh, 0);
    chk("e_re_end_act", e_act, 0);
    b_v = 1'b1; b_idx = 2'd2;
    cyc();
    chk("b_bp1_oh", b_oh, 4'b0100);
    b_idx = 2'd1;
    cyc();
    chk("b_bp2_oh", b_oh, 4'b0100);
    chk("b_bp2_rdy", b_rdy, 0);
    b_idx = 2'd3;
    cyc();
    chk("b_bp3_oh", b_oh, 4'b0100);
    chk("b_bp3_rdy", b_rdy, 1);
    cyc();
    b_v = 1'b0;
    chk("b_bp4_oh", b_oh, 4'b1000);
    chk("b_bp4_act", b_act, 1);
    cyc();
    cyc();
    chk("b_bp6_oh", b_oh, 4'b1000);
    cyc();
    chk("b_bp7_oh", b_oh, 0);
    chk("b_bp7_act", b_act, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
